// File: rtl/tmds_word_aligner.sv
// tmds_word_aligner: finds the TMDS word boundary via control tokens, drives bitslip, flags lock and preamble
module tmds_word_aligner #(
  parameter int CTL_MATCH_COUNT = 8,
  parameter int SEARCH_WINDOW   = 1024,
  parameter int SETTLE_CYCLES   = 4,
  parameter int LOSS_LIMIT      = 4096,
  parameter int PRE_LEN         = 8
) (
  input  logic       clk_1x_in,
  input  logic       reset_in,
  input  logic [9:0] data_in,
  output logic       bitslip,
  output logic [9:0] data_out,
  output logic       data_pre,
  output logic       locked,
  output logic [3:0] slip_count
);
  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] CTL2 = 10'b0101010100;
  localparam logic [9:0] CTL3 = 10'b1010101011;
  typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_WAIT, ST_LOCKED} state_t;
  state_t      state_q, state_d;
  logic [7:0]  match_q, match_d;
  logic [15:0] win_q, win_d, gap_q, gap_d;
  logic [3:0]  wait_q, wait_d, run_q, run_d, slip_q, slip_d;
  logic [9:0]  dout_q;
  logic        bs_q, lock_q, pre_q, pre_d, is_tok;
  assign is_tok = (data_in == CTL0) || (data_in == CTL1) || (data_in == CTL2) || (data_in == CTL3);
  always_comb begin
    state_d = state_q;
    match_d = '0;
    win_d   = '0;
    gap_d   = '0;
    wait_d  = '0;
    slip_d  = slip_q;
    case (state_q)
      ST_SEARCH: begin
        match_d = is_tok ? match_q + 8'd1 : '0;
        win_d   = win_q + 16'd1;
        if (is_tok && match_q == 8'(CTL_MATCH_COUNT - 1)) state_d = ST_LOCKED;
        else if (win_q == 16'(SEARCH_WINDOW - 1)) begin
          state_d = ST_SLIP;
          slip_d  = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
        end
      end
      ST_SLIP: state_d = ST_WAIT;
      ST_WAIT: begin
        wait_d  = wait_q + 4'd1;
        state_d = (wait_q == 4'(SETTLE_CYCLES - 1)) ? ST_SEARCH : ST_WAIT;
      end
      ST_LOCKED: begin
        gap_d   = is_tok ? '0 : gap_q + 16'd1;
        state_d = (!is_tok && gap_q == 16'(LOSS_LIMIT - 1)) ? ST_SEARCH : ST_LOCKED;
      end
    endcase
  end
  // Run length of a repeated token; the previous word is the registered data_out.
  always_comb begin
    run_d = !is_tok ? 4'd0 : (data_in != dout_q) ? 4'd1 : (run_q == 4'd15) ? 4'd15 : run_q + 4'd1;
    pre_d = (state_d == ST_LOCKED) && (run_d >= 4'(PRE_LEN)) && (data_in != CTL0);
  end
  always_ff @(posedge clk_1x_in) begin
    if (reset_in) begin
      state_q <= ST_SEARCH;
      match_q <= '0;
      win_q   <= '0;
      gap_q   <= '0;
      wait_q  <= '0;
      run_q   <= '0;
      slip_q  <= '0;
      dout_q  <= '0;
      bs_q    <= 1'b0;
      lock_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      win_q   <= win_d;
      gap_q   <= gap_d;
      wait_q  <= (state_d == ST_WAIT) ? wait_d : 4'd0;
      run_q   <= run_d;
      slip_q  <= slip_d;
      dout_q  <= data_in;
      bs_q    <= state_d == ST_SLIP;
      lock_q  <= state_d == ST_LOCKED;
      pre_q   <= pre_d;
    end
  end
  assign bitslip    = bs_q;
  assign data_out   = dout_q;
  assign data_pre   = pre_q;
  assign locked     = lock_q;
  assign slip_count = slip_q;
endmodule

// File: tb/tb_tmds_word_aligner.sv
// tb_tmds_word_aligner: directed stimulus with an ISERDES rotation model and a cycle-level reference model
module tb_tmds_word_aligner;
  localparam int MATCH = 8, WIN = 1024, SETTLE = 4, LOSS = 4096, PRE = 8;
  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] CTL2 = 10'b0101010100;
  localparam logic [9:0] CTL3 = 10'b1010101011;
  logic       clk_1x_in = 1'b0, reset_in = 1'b1;
  logic [9:0] data_in = '0;
  logic       bitslip, data_pre, locked;
  logic [9:0] data_out;
  logic [3:0] slip_count;
  int n_tests = 0, n_fail = 0;
  int rot_r = 0;

  tmds_word_aligner dut (
    .clk_1x_in(clk_1x_in), .reset_in(reset_in), .data_in(data_in), .bitslip(bitslip),
    .data_out(data_out), .data_pre(data_pre), .locked(locked), .slip_count(slip_count)
  );

  always #5 clk_1x_in = ~clk_1x_in;

  function automatic bit tok(input logic [9:0] w);
    return w == CTL0 || w == CTL1 || w == CTL2 || w == CTL3;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r = w;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  // Reference model: time-stamped search windows instead of an explicit state machine.
  int rel = 0, win_start = 0, m_tok = 0, m_gap = 0, m_run = 0, m_pos = 0;
  bit m_locked = 0, m_bs = 0, m_pre = 0, chk_en = 0;
  logic [9:0] m_dout = '0;
  always @(posedge clk_1x_in) begin
    if (reset_in) begin
      rel = 0; win_start = 0; m_tok = 0; m_gap = 0; m_run = 0; m_pos = 0;
      m_locked = 0; m_bs = 0; m_pre = 0; m_dout = '0; chk_en = 1;
    end else begin
      m_bs = 0;
      if (m_locked) begin
        if (tok(data_in)) m_gap = 0;
        else if (m_gap == LOSS - 1) begin
          m_locked = 0; m_gap = 0; m_tok = 0; win_start = rel + 1;
        end else m_gap++;
      end else if (rel >= win_start) begin
        m_tok = tok(data_in) ? m_tok + 1 : 0;
        if (m_tok == MATCH) begin
          m_locked = 1; m_gap = 0;
        end else if (rel - win_start == WIN - 1) begin
          m_bs = 1; m_pos = (m_pos + 1) % 10; m_tok = 0; win_start = rel + 2 + SETTLE;
        end
      end
      m_run = !tok(data_in) ? 0 : (data_in == m_dout) ? (m_run < 15 ? m_run + 1 : 15) : 1;
      m_pre = m_locked && m_run >= PRE && data_in != CTL0;
      m_dout = data_in;
      rel++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, rel, act, exp);
    end
  endtask

  always @(negedge clk_1x_in) if (chk_en) begin
    chk("m_bitslip", bitslip, m_bs);
    chk("m_locked", locked, m_locked);
    chk("m_data_out", data_out, m_dout);
    chk("m_data_pre", data_pre, m_pre);
    chk("m_slip_count", slip_count, m_pos);
  end

  // Drive one word through the ISERDES model; returns with outputs showing the response to it.
  task automatic tick(input logic [9:0] w);
    data_in = rotl(w, rot_r);
    @(negedge clk_1x_in);
    if (bitslip) rot_r = (rot_r + 1) % 10;
  endtask

  function automatic logic [9:0] nt(input int i);
    return i[0] ? 10'h3FF : 10'h000;
  endfunction

  int fall, pulses[$];

  initial begin
    for (int i = 0; i < 3; i++) tick(10'($urandom_range(0, 1023)));
    chk("rst_data_out", data_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_slip_count", slip_count, 0);
    // aligned lock from reset release
    reset_in = 1'b0;
    rot_r = 0;
    for (int i = 0; i < 20; i++) begin
      tick(CTL0);
      if (i == 6) chk("lock_c7", locked, 0);
      if (i == 7) chk("lock_c8", locked, 1);
      if (i == 3) chk("dout_ctl0", data_out, CTL0);
    end
    // preamble
    for (int i = 0; i < 10; i++) begin
      tick(CTL1);
      chk("pre_ctl1", data_pre, i >= 7);
    end
    for (int i = 0; i < 8; i++) begin
      tick(CTL0);
      chk("pre_ctl0", data_pre, 0);
    end
    for (int i = 0; i < 8; i++) begin
      tick(i < 7 ? CTL2 : CTL3);
      chk("pre_ctl2_3", data_pre, 0);
    end
    // loss of lock
    for (int i = 0; i < LOSS - 1; i++) tick(nt(i));
    tick(CTL1);
    chk("loss_held", locked, 1);
    for (int i = 0; i < LOSS; i++) begin
      tick(nt(i));
      if (i == LOSS - 2) chk("loss_pre", locked, 1);
      if (i == LOSS - 1) chk("loss_fall", locked, 0);
    end
    fall = rel;
    for (int i = 0; i < 1100 && !bitslip; i++) tick(nt(i));
    chk("loss_slip_seen", bitslip, 1);
    chk("loss_slip_delay", rel - fall, 1024);
    // misaligned lock: stream rotated by 3
    reset_in = 1'b1;
    tick(CTL0);
    reset_in = 1'b0;
    rot_r = 3;
    for (int i = 0; i < 9000 && !locked; i++) begin
      tick(CTL0);
      if (bitslip) pulses.push_back(rel);
    end
    chk("mis_locked", locked, 1);
    chk("mis_lock_cycle", rel, 7211);
    chk("mis_pulses", pulses.size(), 7);
    chk("mis_pulse0", pulses[0], 1024);
    chk("mis_pulse1", pulses[1], 2053);
    chk("mis_pulse6", pulses[6], 7198);
    chk("mis_slip_count", slip_count, 7);
    for (int i = 0; i < 30; i++) tick(CTL0);
    // reset during the slip cycle
    reset_in = 1'b1;
    tick(10'h000);
    reset_in = 1'b0;
    for (int i = 0; i < 1100 && !bitslip; i++) tick(10'h000);
    chk("ms_first_pulse", rel, 1024);
    reset_in = 1'b1;
    tick(10'h000);
    chk("ms_bitslip_cut", bitslip, 0);
    chk("ms_slip_count", slip_count, 0);
    reset_in = 1'b0;
    for (int i = 0; i < 1100 && !bitslip; i++) tick(10'h000);
    chk("ms_pulse_seen", bitslip, 1);
    chk("ms_pulse_again", rel, 1024);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tmds_word_aligner.md
# tmds_word_aligner

Per-channel TMDS word-alignment stage. It sits between the ISERDES deserializer and `error_detector`. It scans raw 10-bit words for TMDS control tokens and pulses `bitslip` to the deserializer until the word boundary is found. Once aligned, it declares lock and forwards registered words plus a preamble flag (`data_pre`) downstream.

## Interface
- `CTL_MATCH_COUNT`, default 8: consecutive control tokens required to declare lock (2..255).
- `SEARCH_WINDOW`, default 1024: cycles spent searching at one slip position before slipping (2..65535).
- `SETTLE_CYCLES`, default 4: wait cycles after a bitslip pulse before searching resumes (1..15).
- `LOSS_LIMIT`, default 4096: consecutive non-token cycles while locked that drop lock (2..65535).
- `PRE_LEN`, default 8: identical non-CTL0 tokens required to flag preamble (2..15).
- `clk_1x_in`, in, 1: pixel clock. One clock domain only.
- `reset_in`, in, 1: synchronous, active-high reset.
- `data_in`, in, 10: raw deserialized word, possibly misaligned.
- `bitslip`, out, 1: single-cycle slip request to the ISERDES.
- `data_out`, out, 10: `data_in` delayed by one register stage.
- `data_pre`, out, 1: preamble detected; aligned with `data_out`.
- `locked`, out, 1: word alignment established.
- `slip_count`, out, 4: current slip position, 0..9.

## Operation
- **Control tokens:** CTL0=`1101010100`, CTL1=`0010101011`, CTL2=`0101010100`, CTL3=`1010101011`. `is_tok` means `data_in` equals any of the four.
- **State machine:** ST_SEARCH, ST_SLIP, ST_WAIT, ST_LOCKED. Reset enters ST_SEARCH.
- **ST_SEARCH:**
  - `match_cnt` (8 bits) increments on `is_tok` and clears to 0 on a non-token.
  - `win_cnt` (16 bits) increments every cycle.
  - If `is_tok` and `match_cnt == CTL_MATCH_COUNT-1`, go to ST_LOCKED.
  - Otherwise, if `win_cnt == SEARCH_WINDOW-1`, go to ST_SLIP.
  - Lock has priority when both conditions occur in the same cycle.
- **ST_SLIP:**
  - Lasts exactly one cycle, with `bitslip=1` during that cycle.
  - `slip_count` increments modulo 10 (9 wraps to 0).
  - Then go to ST_WAIT.
- **ST_WAIT:**
  - Counts `SETTLE_CYCLES` cycles, ignoring `data_in`.
  - Then go to ST_SEARCH with `match_cnt` and `win_cnt` cleared.
- **ST_LOCKED:**
  - `locked=1`.
  - `gap_cnt` (16 bits) clears on `is_tok` and increments otherwise.
  - If a non-token is seen with `gap_cnt == LOSS_LIMIT-1`, go to ST_SEARCH with all counters cleared.
  - No immediate bitslip on loss of lock; `slip_count` is held.
- **Preamble:**
  - `run_cnt` (4 bits, saturating at 15) counts consecutive words equal to the previous word while that word is a token.
  - It is set to 1 on a token that differs from the previous word, and to 0 on a non-token.
  - `data_pre` (registered) = `locked` state && `run_cnt` (next value) >= `PRE_LEN` && word != CTL0.
- **Reset mid-operation:** `reset_in` in any state (including ST_SLIP) clears everything on the next edge; a `bitslip` pulse in progress is cut to that one cycle.

## Timing
- **Reset values:** `bitslip=0`, `data_out=0`, `data_pre=0`, `locked=0`, `slip_count=0`, state ST_SEARCH, all counters 0.
- **Data path:** `data_out` lags `data_in` by 1 cycle, in all states.
- **Lock latency:** `locked` rises on the edge after the `CTL_MATCH_COUNT`-th consecutive token is sampled. With clean tokens from reset release at cycle 0, `locked` is 1 from cycle 8.
- **Lock loss:** `locked` falls on the edge after the `LOSS_LIMIT`-th consecutive non-token.
- **Slip cadence:** with no lock, `bitslip` pulses once every `SEARCH_WINDOW` + 1 + `SETTLE_CYCLES` cycles.
  - The first pulse occurs in cycle `SEARCH_WINDOW` after reset release.
  - The next search begins `SETTLE_CYCLES` cycles after each pulse.
- **Preamble flag:** `data_pre` is registered together with `data_out`, so both refer to the same word.

## Test plan
- **Reset:** hold `reset_in` for 3 cycles with random data → all outputs 0; `bitslip` never asserted.
- **Aligned lock:** feed CTL0 continuously from reset release → `locked=1` at cycle 8, `bitslip` never pulses, `data_out` equals `data_in` delayed by 1 cycle.
- **Misaligned lock:** bench ISERDES model rotates the stream by 3 bits; each `bitslip` rotates it by 1 → pulses at cycles 1024, 2053, 3082, …; lock follows at the slip that realigns the stream; `slip_count` reports that position; no further pulses after lock.
- **Loss of lock:** after lock, drive 4095 non-token words then one CTL1 → lock held; then drive 4096 non-tokens → `locked` falls 1 cycle after the last one; a `bitslip` pulse follows 1024 cycles later if tokens stay absent.
- **Preamble:** while locked, drive 8×CTL1 → `data_pre=1` on the `data_out` cycle of the 8th word and stays high while CTL1 repeats. 8×CTL0 → `data_pre` stays 0. 7×CTL2 then CTL3 → `data_pre` stays 0.
- **Reset mid-slip:** assert `reset_in` during the ST_SLIP cycle → `bitslip` is 0 next cycle, `slip_count` returns to 0, and the first pulse recurs 1024 cycles after release.
